// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer_if
// Purpose  : Handshake and operand bundle between the execute stage and the
//            iterative RV32M multiply/divide sequencer.
// Ports    : master - execute-stage side (drives request, sees result/stall)
//            slave  - sequencer side (sees request, drives result/stall)
//            start_i/funct3_i/op_a_i/op_b_i/rd_i : operation request
//            flush_i      : kill the in-flight operation
//            next_ready_i : downstream accepts the result
//            stall_o/busy_o/valid_o/result_o/rd_o : status and result
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        next_ready_i;
  logic        stall_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, rd_i, flush_i, next_ready_i,
    input  stall_o, busy_o, valid_o, result_o, rd_o
  );

  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, rd_i, flush_i, next_ready_i,
    output stall_o, busy_o, valid_o, result_o, rd_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative RV32M multiply/divide unit. One radix-2 step per cycle
//            on operand magnitudes (shift-add multiply, restoring divide),
//            sign correction on the final step, result held until accepted.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous, active-high
//            bus   - muldiv_sequencer_if.slave (request, flush, result)
// Params   : FAST_SPECIAL - 1: divide-by-zero and signed overflow finish
//            directly from IDLE without iterating
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int FAST_SPECIAL = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  f3;
  logic [4:0]  tag;
  logic [63:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;     // multiplicand / divisor magnitude
  logic        neg_q;    // negate product or quotient at the end
  logic        neg_r;    // negate remainder at the end
  logic [31:0] result;
  logic [4:0]  rd;
  logic        valid;
  logic        busy;

  // ---------------------------------------------------------------- request decode
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] special_result;

  always_comb begin
    // MULH, MULHSU, DIV, REM treat rs1 as signed; only MULH, DIV, REM treat rs2 as signed
    sign_a   = bus.op_a_i[31] & ((bus.funct3_i == 3'b001) | (bus.funct3_i == 3'b010) |
                                 (bus.funct3_i == 3'b100) | (bus.funct3_i == 3'b110));
    sign_b   = bus.op_b_i[31] & ((bus.funct3_i == 3'b001) | (bus.funct3_i == 3'b100) |
                                 (bus.funct3_i == 3'b110));
    mag_a    = sign_a ? (32'd0 - bus.op_a_i) : bus.op_a_i;
    mag_b    = sign_b ? (32'd0 - bus.op_b_i) : bus.op_b_i;
    div_zero = bus.funct3_i[2] & (bus.op_b_i == 32'd0);
    div_ovf  = bus.funct3_i[2] & ~bus.funct3_i[0] &
               (bus.op_a_i == 32'h8000_0000) & (bus.op_b_i == 32'hFFFF_FFFF);
    special  = (FAST_SPECIAL != 0) & (div_zero | div_ovf);
    if (bus.funct3_i[1])
      special_result = div_zero ? bus.op_a_i : 32'd0;
    else
      special_result = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
  end

  // ---------------------------------------------------------------- datapath step
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] step_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] final_result;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_trial = acc[63:31] - {1'b0, opnd};
    if (f3[2])
      step_next = div_trial[32] ? {acc[62:0], 1'b0}
                                : {div_trial[31:0], acc[30:0], 1'b1};
    else
      step_next = {mul_sum, acc[31:1]};

    // sign correction applied to the outcome of the last step
    prod_fix = neg_q ? (64'd0 - step_next) : step_next;
    quo_fix  = neg_q ? (32'd0 - step_next[31:0])  : step_next[31:0];
    rem_fix  = neg_r ? (32'd0 - step_next[63:32]) : step_next[63:32];

    if (f3[2])
      final_result = f3[1] ? rem_fix : quo_fix;
    else
      final_result = (f3[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
  end

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      f3     <= 3'd0;
      tag    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= 32'd0;
      rd     <= 5'd0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            f3   <= bus.funct3_i;
            tag  <= bus.rd_i;
            busy <= 1'b1;
            if (special) begin
              result <= special_result;
              rd     <= bus.rd_i;
              valid  <= 1'b1;
              state  <= DONE;
            end else begin
              acc   <= {32'd0, mag_a};
              opnd  <= mag_b;
              cnt   <= 5'd31;
              // a zero divisor keeps the all-ones quotient unsigned
              neg_q <= bus.funct3_i[2] ? ((sign_a ^ sign_b) & (bus.op_b_i != 32'd0))
                                       : (sign_a ^ sign_b);
              neg_r <= sign_a;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= step_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            result <= final_result;
            rd     <= tag;
            valid  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.next_ready_i) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall_o  = ((state == IDLE) & bus.start_i & ~bus.flush_i) |
                        (state == BUSY) |
                        ((state == DONE) & ~bus.next_ready_i);
  assign bus.busy_o   = busy;
  assign bus.valid_o  = valid;
  assign bus.result_o = result;
  assign bus.rd_o     = rd;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer. Expected results come
//            from an arithmetic reference model and are queued at issue time,
//            then popped when valid_o appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic clk;
  logic reset;
  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.FAST_SPECIAL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] xa, xb, za, zb, p;
    int sa, sb2;
    xa = {{32{a[31]}}, a};
    xb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    sa  = $signed(a);
    sb2 = $signed(b);
    case (f)
      3'd0: begin p = za * zb; return p[31:0]; end
      3'd1: begin p = xa * xb; return p[63:32]; end
      3'd2: begin p = xa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb2);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb2);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Drive a request in the current cycle (cycle 0) and queue its expectation.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
    exp_t e;
    bus.start_i  = 1'b1;
    bus.funct3_i = f;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    bus.rd_i     = r;
    e.res = model(f, a, b);
    e.rd  = r;
    e.lat = latency(f, a, b);
    sb.push_back(e);
    #1;
    check("stall_accept", bus.stall_o, 1);
  endtask

  // Wait for the result, scrambling operands meanwhile; hold it for 'hold' cycles.
  task automatic collect(input int hold);
    exp_t e;
    int   cyc;
    bit   got;
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) e = sb.pop_front();
    else begin e.res = 0; e.rd = 0; e.lat = 0; end
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.start_i  = 1'b0;
      bus.funct3_i = 3'($urandom);
      bus.op_a_i   = $urandom;
      bus.op_b_i   = $urandom;
      bus.rd_i     = 5'($urandom);
      #1;
      if (bus.valid_o) got = 1;
      else check("stall_busy", bus.stall_o, 1);
    end
    check("valid_seen", got, 1);
    check("latency", cyc, e.lat);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        bus.next_ready_i = (h == hold);
        #1;
      end
      check("valid_done", bus.valid_o, 1);
      check("result", bus.result_o, e.res);
      check("rd", bus.rd_o, e.rd);
      check("stall_done", bus.stall_o, (h < hold) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    check("valid_idle", bus.valid_o, 0);
    check("busy_idle", bus.busy_o, 0);
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    launch(f, a, b, r);
    collect(0);
  endtask

  initial begin
    bit seen;
    reset            = 1'b1;
    bus.start_i      = 1'b0;
    bus.funct3_i     = 3'd0;
    bus.op_a_i       = 32'd0;
    bus.op_b_i       = 32'd0;
    bus.rd_i         = 5'd0;
    bus.flush_i      = 1'b0;
    bus.next_ready_i = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", bus.valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_result", bus.result_o, 0);
    check("rst_rd", bus.rd_o, 0);
    check("rst_stall", bus.stall_o, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // multiply family
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3);

    // divide family
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
    do_op(3'b101, 32'd100, 32'd7, 5'd7);
    do_op(3'b111, 32'd100, 32'd7, 5'd8);

    // special cases on the fast path
    do_op(3'b101, 32'h1234, 32'd0, 5'd9);
    do_op(3'b110, 32'h1234, 32'd0, 5'd10);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    do_op(3'b100, 32'hFFFF_FFF0, 32'd0, 5'd13);

    // mixed-sign and random operands
    do_op(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd14);
    do_op(3'b001, 32'h8000_0000, 32'h7FFF_FFFF, 5'd15);
    for (int i = 0; i < 6; i++)
      do_op(3'(i + 2), $urandom, $urandom, 5'(i + 16));

    // flush in cycle 10 of a DIV; nothing is delivered
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'b100;
    bus.op_a_i   = 32'd1000;
    bus.op_b_i   = 32'd3;
    bus.rd_i     = 5'd22;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = (c == 10);
      #1;
      if (c == 10) check("flush_no_valid", bus.valid_o, 0);
    end
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check("flush_busy", bus.busy_o, 0);
    check("flush_stall", bus.stall_o, 0);
    check("flush_valid", bus.valid_o, 0);
    do_op(3'b101, 32'd100, 32'd7, 5'd23);

    // result held while downstream is not ready (cycles 33-40)
    bus.next_ready_i = 1'b0;
    launch(3'b000, 32'd3, 32'd4, 5'd24);
    collect(8);

    // reset mid-BUSY abandons the operation
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'b000;
    bus.op_a_i   = 32'd9;
    bus.op_b_i   = 32'd9;
    bus.rd_i     = 5'd25;
    repeat (5) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("arst_valid", bus.valid_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_result", bus.result_o, 0);
    check("arst_rd", bus.rd_o, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.valid_o) seen = 1;
    end
    check("arst_no_valid", seen, 0);
    do_op(3'b111, 32'hFFFF_FFFF, 32'd10, 5'd26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
